// File: rtl/cont_dec.sv
// cont_dec: divides clk_in by 2*HALF_PERIOD into a registered 50%-duty clk_out with a toggle tick
module cont_dec #(
    parameter int HALF_PERIOD = 10,
    parameter int CNT_W       = $clog2(HALF_PERIOD)
) (
    input  logic             clk_in,
    input  logic             reset,
    output logic             clk_out,
    output logic [CNT_W-1:0] count,
    output logic             tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    logic [CNT_W-1:0] count_d, count_q;
    logic             clk_out_d, clk_out_q;
    logic             tick_d, tick_q;
    // advance the edge counter; at the last edge of a half period wrap, toggle and pulse tick
    always_comb begin
        count_d   = count_q + ONE;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        if (count_q == LAST) begin
            count_d   = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = 1'b1;
        end else if (count_q > LAST) begin
            count_d = '0;
        end
    end
    // state flops; reset clears everything at once so clk_out can never be high in reset
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end
    assign clk_out = clk_out_q;
    assign count   = count_q;
    assign tick    = tick_q;
endmodule

// File: tb/tb_cont_dec.sv
// tb_cont_dec: random reset/run stimulus checked against an edge-count model of the divider
module tb_cont_dec;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       co10, tk10, co3, tk3;
    logic [3:0] c10;
    logic [1:0] c3;
    int         n = 0;
    int         checks = 0;
    int         errors = 0;

    cont_dec u10 (.clk_in(clk), .reset(rst_n), .clk_out(co10), .count(c10), .tick(tk10));
    cont_dec #(.HALF_PERIOD(3)) u3 (.clk_in(clk), .reset(rst_n), .clk_out(co3), .count(c3), .tick(tk3));

    always #5 clk = ~clk;

    // model: number of rising edges seen since reset was last released
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else n <= n + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edges=%0d, t=%0t)", name, act, exp, n, $time);
        end
    endtask

    task automatic check_all();
        chk("count10", 32'(c10), n % 10);
        chk("clk10", 32'(co10), (n / 10) % 2);
        chk("tick10", 32'(tk10), int'(n > 0 && n % 10 == 0));
        chk("count3", 32'(c3), n % 3);
        chk("clk3", 32'(co3), (n / 3) % 2);
        chk("tick3", 32'(tk3), int'(n > 0 && n % 3 == 0));
    endtask

    // compare every cycle, away from the rising edge
    always @(negedge clk) check_all();

    initial begin
        int  d;
        bit  found;
        repeat (3) @(negedge clk);
        chk("rst_clk_lit", 32'(co10), 0);
        chk("rst_cnt_lit", 32'(c10), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        chk("e9_clk_lit", 32'(co10), 0);
        chk("e9_cnt_lit", 32'(c10), 9);
        chk("e9_tick_lit", 32'(tk10), 0);
        @(posedge clk);
        #1;
        chk("e10_clk_lit", 32'(co10), 1);
        chk("e10_cnt_lit", 32'(c10), 0);
        chk("e10_tick_lit", 32'(tk10), 1);
        chk("e10_cnt3_lit", 32'(c3), 1);
        chk("e10_clk3_lit", 32'(co3), 1);
        repeat (10) @(posedge clk);
        #1;
        chk("e20_clk_lit", 32'(co10), 0);
        chk("e20_tick_lit", 32'(tk10), 1);
        repeat (80) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (co10 === 1'b1 && c10 === 4'd6) found = 1'b1;
        end
        chk("find_high_cnt6", 32'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_clk_lit", 32'(co10), 0);
        chk("async_cnt_lit", 32'(c10), 0);
        chk("async_tick_lit", 32'(tk10), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("restart_e10_lit", 32'(co10), 1);
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(1, 60)) @(negedge clk);
            d = $urandom_range(1, 6);
            if (d >= 4) d += 2;
            #(d) rst_n = 1'b0;
            #1 check_all();
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (45) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
